sobel_core: RTL and testbench

Streaming 3×3 Sobel edge detector for 8-bit grayscale images in raster order, one pixel per accepted beat. It holds two previous rows in line buffers, forms a 3×3 window and computes |Gx|+|Gy| saturated to 8 bits. It produces one output per interior pixel. It sits between a pixel source (file reader or camera front-end) and a pixel sink, with no back-pressure.

---
 rtl/sobel_pkg.sv | 30 +++
 rtl/sobel_line_buffer.sv | 32 +++
 rtl/sobel_core.sv | 114 +++++++++++
 tb/tb_sobel_core.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Purpose: shared widths, types and helpers for the streaming Sobel edge detector.
// Contents: pixel/gradient/magnitude typedefs, gradient pair payload, sign-extend and abs helpers.
package sobel_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned GRAD_W  = 11;
    localparam int unsigned MAG_W   = 11;
    localparam int unsigned MAG_MAX = 255;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [MAG_W-1:0]  mag_t;

    // Gradient pair carried between the gradient and magnitude stages
    typedef struct packed {
        grad_t gx;
        grad_t gy;
    } grad_pair_t;

    // Zero-extend an unsigned pixel into the signed gradient domain
    function automatic grad_t pix2grad(input pix_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    // |g|; -1020 negates safely within 11 bits
    function automatic mag_t abs_grad(input grad_t g);
        return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Purpose: one image row of pixel storage, addressed by the shared column pointer.
// Ports:
//   clk        - clock
//   i_we       - write enable (one accepted pixel)
//   i_addr     - column address, shared for read and write
//   i_wdata    - pixel written at i_addr
//   o_rdata_c  - combinational read of the entry at i_addr (value before this write)
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  pix_t              i_wdata,
    output pix_t              o_rdata_c
);

    // Contents need no reset: never consumed before being overwritten
    pix_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/sobel_core.sv
// Purpose: streaming 3x3 Sobel edge detector, |Gx|+|Gy| saturated to 8 bits,
//          one output per interior pixel, fixed 2-edge latency after the window completes.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   pixel_in   - raster-order input pixel
//   valid_in   - pixel_in accepted on this edge
//   pixel_out  - edge magnitude of the window centre
//   valid_out  - pixel_out valid
module sobel_core
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH  = 512,
    parameter int unsigned HEIGHT = 512
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             valid_in,
    output logic [PIX_W-1:0] pixel_out,
    output logic             valid_out
);

    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    pix_t             w_lb1;
    pix_t             w_lb2;
    pix_t             r_win [0:2][0:2];
    logic             r_win_valid;
    grad_pair_t       w_grad;
    grad_pair_t       r_grad;
    logic             r_grad_valid;
    mag_t             w_mag;

    // Row-1 buffer: takes the new pixel
    sobel_line_buffer #(.DEPTH(WIDTH), .ADDR_W(COL_W)) u_lb1 (
        .clk       (clk),
        .i_we      (valid_in),
        .i_addr    (r_col),
        .i_wdata   (pixel_in),
        .o_rdata_c (w_lb1)
    );

    // Row-2 buffer: takes the displaced row-1 entry
    sobel_line_buffer #(.DEPTH(WIDTH), .ADDR_W(COL_W)) u_lb2 (
        .clk       (clk),
        .i_we      (valid_in),
        .i_addr    (r_col),
        .i_wdata   (w_lb1),
        .o_rdata_c (w_lb2)
    );

    // Raster position of the next accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_in) begin
            if (r_col == COL_W'(WIDTH - 1)) begin
                r_col <= '0;
                if (r_row == ROW_W'(HEIGHT - 1)) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Window shift: column 2 is newest, row 0 is oldest
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
            end
            r_win[0][2] <= w_lb2;
            r_win[1][2] <= w_lb1;
            r_win[2][2] <= pixel_in;
        end
    end

    assign w_grad.gx = (pix2grad(r_win[0][2]) + (pix2grad(r_win[1][2]) <<< 1) + pix2grad(r_win[2][2]))
                     - (pix2grad(r_win[0][0]) + (pix2grad(r_win[1][0]) <<< 1) + pix2grad(r_win[2][0]));
    assign w_grad.gy = (pix2grad(r_win[2][0]) + (pix2grad(r_win[2][1]) <<< 1) + pix2grad(r_win[2][2]))
                     - (pix2grad(r_win[0][0]) + (pix2grad(r_win[0][1]) <<< 1) + pix2grad(r_win[0][2]));

    assign w_mag = abs_grad(r_grad.gx) + abs_grad(r_grad.gy);

    // Pipeline: window valid -> gradients -> saturated magnitude
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_grad       <= '0;
            r_grad_valid <= 1'b0;
            pixel_out    <= '0;
            valid_out    <= 1'b0;
        end else begin
            // Only a full 3x3 inside one row band and one frame is flagged
            r_win_valid  <= valid_in && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
            r_grad       <= w_grad;
            r_grad_valid <= r_win_valid;
            pixel_out    <= (w_mag > MAG_W'(MAG_MAX)) ? PIX_W'(MAG_MAX) : w_mag[PIX_W-1:0];
            valid_out    <= r_grad_valid;
        end
    end

endmodule

// File: tb/tb_sobel_core.sv
// Purpose: randomized scoreboard bench for sobel_core (8x8 frames).
module tb_sobel_core;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_out;
    logic       valid_out;

    always #5 clk = ~clk;

    sobel_core #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .pixel_out (pixel_out),
        .valid_out (valid_out)
    );

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cyc   = 0;
    int   img [H][W];
    int   rnd [H*W];
    int   m_row = 0;
    int   m_col = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Sobel on the stored image, window rows r-2..r, cols c-2..c
    function automatic int ref_mag(input int r, input int c);
        int gx, gy, m;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    function automatic int pat(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c < 4) ? 0 : 255;
            2:       return 10 * c;
            default: return rnd[r*W + c];
        endcase
    endfunction

    // Monitor: every valid output must match the oldest expectation, on its due cycle
    always @(negedge clk) begin
        if (valid_out) begin
            exp_t e;
            n_out++;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_output: got pixel_out=%0d, expected no output (t=%0t)", pixel_out, $time);
            end else begin
                e = q.pop_front();
                check("pixel_out", int'(pixel_out), e.val);
                check("output_cycle", cyc, e.due);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    // Drive one pixel; accepted on the next rising edge, output due two edges later
    task automatic drive_pixel(input int p);
        @(negedge clk);
        pixel_in = 8'(p);
        valid_in = 1'b1;
        img[m_row][m_col] = p;
        if (m_row >= 2 && m_col >= 2) q.push_back('{ref_mag(m_row, m_col), cyc + 3});
        if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic send_frame(input int kind, input int gap_pct);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(3, 1));
                drive_pixel(pat(kind, r, c));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        idle(2);
        check("queue_drained", q.size(), 0);
    endtask

    task automatic frame_test(input string name, input int kind, input int gap_pct, input int nframes);
        int base;
        base = n_out;
        for (int f = 0; f < nframes; f++) send_frame(kind, gap_pct);
        drain();
        check(name, n_out - base, 36 * nframes);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int i = 0; i < H*W; i++) rnd[i] = $urandom_range(255);

        idle(3);
        check("reset_pixel_out", int'(pixel_out), 0);
        check("reset_valid_out", int'(valid_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        frame_test("const_count", 0, 0, 1);
        frame_test("vstep_count", 1, 0, 1);
        frame_test("ramp_count", 2, 0, 1);
        frame_test("rand_gaps_count", 3, 30, 1);
        frame_test("rand_cont_count", 3, 0, 1);

        // Back-to-back: ramp then constant, no idle at the seam
        base = n_out;
        send_frame(2, 0);
        send_frame(0, 0);
        drain();
        check("seam_count", n_out - base, 72);

        // Mid-frame reset with results in flight
        for (int k = 0; k < 30; k++) drive_pixel(pat(2, k / W, k % W));
        @(posedge clk);
        #1;
        check("valid_before_reset", int'(valid_out), 1);
        valid_in = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("valid_out_in_reset", int'(valid_out), 0);
        check("pixel_out_in_reset", int'(pixel_out), 0);
        q.delete();
        m_row = 0;
        m_col = 0;
        idle(3);
        check("valid_out_held_reset", int'(valid_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_test("after_reset_count", 0, 0, 1);

        frame_test("rand_gaps2_count", 3, 50, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
